reg_load_arbiter: RTL



---
 rtl/reg_load_arbiter_pkg.sv | 20 ++
 rtl/reg_load_arbiter_rr_picker.sv | 28 ++
 rtl/reg_load_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/reg_load_arbiter_pkg.sv
// Shared definitions for reg_load_arbiter: requester count, owner index width,
// FSM state encoding and a one-hot grant helper.
package reg_load_arbiter_pkg;

   localparam int NREQ    = 4;
   localparam int OWNER_W = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [NREQ-1:0] onehot(input logic [OWNER_W-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/reg_load_arbiter_rr_picker.sv
// Round-robin picker: first requester at or after rr_ptr, wrapping modulo NREQ.
// Latency: purely combinational. Backpressure: none, it only reports found/winner.
module reg_load_arbiter_rr_picker
   import reg_load_arbiter_pkg::*;
(
   input  logic [NREQ-1:0]    req,
   input  logic [OWNER_W-1:0] rr_ptr,
   output logic               found,
   output logic [OWNER_W-1:0] winner
);

   logic [OWNER_W-1:0] idx;

   // Scan from the farthest offset down so the nearest requester is written last and wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = rr_ptr + OWNER_W'(k);
         if (req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/reg_load_arbiter.sv
// Shares one N-bit register among 4 requesters, round-robin with optional locked bursts.
// Latency: req sampled at an edge loads q/gnt at that same edge. Backpressure: losers and
// non-owners simply hold req; BURST_LIMIT_EN caps a locked burst at MAX_BURST loads.
module reg_load_arbiter
   import reg_load_arbiter_pkg::*;
#(
   parameter int N = 8
`ifdef BURST_LIMIT_EN
   , parameter int MAX_BURST = 4
   , parameter int CNT_W     = 3
`endif
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     lock,
   input  logic [NREQ*N-1:0]   d_in,
   output logic [NREQ-1:0]     gnt,
   output logic [N-1:0]        q,
   output logic [OWNER_W-1:0]  owner,
   output logic                q_valid
);

   state_t             state_q,   state_d;
   logic [OWNER_W-1:0] rr_ptr_q,  rr_ptr_d;
   logic [N-1:0]       q_q,       q_d;
   logic [OWNER_W-1:0] owner_q,   owner_d;
   logic [NREQ-1:0]    gnt_q,     gnt_d;
   logic               q_valid_q, q_valid_d;

   logic               found;
   logic [OWNER_W-1:0] winner;
   logic [OWNER_W-1:0] sel_idx;
   logic [N-1:0]       sel_dat;
   logic               burst_hit;

`ifdef BURST_LIMIT_EN
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
   assign burst_hit = (burst_cnt_q == CNT_W'(MAX_BURST));
`else
   assign burst_hit = 1'b0;
`endif

   reg_load_arbiter_rr_picker u_picker (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .found  (found),
      .winner (winner)
   );

   // In BUSY the owner's slice is reloaded; otherwise the fresh arbitration winner's slice.
   assign sel_idx = (state_q == ST_BUSY) ? owner_q : winner;
   assign sel_dat = d_in[int'(sel_idx) * N +: N];

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      q_d       = q_q;
      owner_d   = owner_q;
      gnt_d     = '0;
      q_valid_d = q_valid_q;
`ifdef BURST_LIMIT_EN
      burst_cnt_d = burst_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               q_d       = sel_dat;
               owner_d   = winner;
               gnt_d     = onehot(winner);
               q_valid_d = 1'b1;
               rr_ptr_d  = winner + OWNER_W'(1);
`ifdef BURST_LIMIT_EN
               burst_cnt_d = CNT_W'(1);
`endif
               if (lock[winner]) begin
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            // Leaving BUSY costs one edge with no load so the others see a clean re-arbitration.
            if (req[owner_q] && lock[owner_q] && !burst_hit) begin
               q_d   = sel_dat;
               gnt_d = onehot(owner_q);
`ifdef BURST_LIMIT_EN
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         q_q       <= '0;
         owner_q   <= '0;
         gnt_q     <= '0;
         q_valid_q <= 1'b0;
`ifdef BURST_LIMIT_EN
         burst_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         q_q       <= q_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         q_valid_q <= q_valid_d;
`ifdef BURST_LIMIT_EN
         burst_cnt_q <= burst_cnt_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign q       = q_q;
   assign owner   = owner_q;
   assign q_valid = q_valid_q;

endmodule
